// File: rtl/jpeg_pkg.sv
// Shared types for the JPEG decoder back end: pixel/block containers,
// channel encoding and the MCU assembler state set.
package jpeg_pkg;

    localparam int CH         = 3;
    localparam int CW         = $clog2(CH + 1);
    localparam int MCU_BLOCKS = 4;

    typedef logic [8:0]        pix_t;
    typedef pix_t [7:0]        row_t;
    typedef row_t [7:0]        block_t;
    typedef logic [CW-1:0]     ch_t;

    localparam ch_t CH_Y  = ch_t'(0);
    localparam ch_t CH_CB = ch_t'(1);
    localparam ch_t CH_CR = ch_t'(2);

    typedef enum logic [1:0] {
        FILL_Y  = 2'd0,
        FILL_CB = 2'd1,
        FILL_CR = 2'd2,
        DRAIN   = 2'd3
    } asm_state_t;

endpackage

// File: rtl/mcu_block_bank.sv
// Four-block pixel store with a per-block write mask and a single
// 8-pixel row read port. Contents are intentionally not reset.
module mcu_block_bank
    import jpeg_pkg::*;
(
    input  logic                  clk,
    input  logic [MCU_BLOCKS-1:0] i_we,
    input  block_t [3:0]          i_wdata,
    input  logic [1:0]            i_rblk,
    input  logic [2:0]            i_rrow,
    output row_t                  o_rdata
);

    block_t [3:0] r_mem;

    always_ff @(posedge clk) begin
        for (int b = 0; b < MCU_BLOCKS; b++) begin
            if (i_we[b]) begin
                r_mem[b] <= i_wdata[b];
            end
        end
    end

    assign o_rdata = r_mem[i_rblk][i_rrow];

endmodule

// File: rtl/mcu_assembler.sv
// Collects one 4:2:0 MCU (4 Y beats, one Cb beat, one Cr beat) and drains
// it as 32 rows of co-sited Y/Cb/Cr pixels under valid/ready handshake.
module mcu_assembler
    import jpeg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] valid_in,
    input  ch_t        ch_in,
    input  block_t     block_1_in,
    input  block_t     block_2_in,
    input  block_t     block_3_in,
    input  block_t     block_4_in,
    output logic       ready_out,
    output row_t       y_out,
    output row_t       cb_out,
    output row_t       cr_out,
    output logic [1:0] blk_out,
    output logic [2:0] row_out,
    output logic       last_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       err_out
);

    asm_state_t r_state;
    logic [1:0] r_ycnt;
    logic [1:0] r_bcnt;
    logic [2:0] r_rcnt;
    logic       r_err;

    asm_state_t w_state_nxt;
    logic [1:0] w_ycnt_nxt;
    logic [1:0] w_bcnt_nxt;
    logic [2:0] w_rcnt_nxt;
    logic       w_err_nxt;
    logic [3:0] w_we_y;
    logic [3:0] w_we_cb;
    logic [3:0] w_we_cr;
    logic       w_beat;
    logic       w_last;
    row_t       w_y_row;
    row_t       w_cb_row;
    row_t       w_cr_row;

    assign w_beat = (valid_in != 4'b0000);
    assign w_last = (r_bcnt == 2'd3) && (r_rcnt == 3'd7);

    always_comb begin
        w_state_nxt = r_state;
        w_ycnt_nxt  = r_ycnt;
        w_bcnt_nxt  = r_bcnt;
        w_rcnt_nxt  = r_rcnt;
        w_err_nxt   = 1'b0;
        w_we_y      = 4'b0000;
        w_we_cb     = 4'b0000;
        w_we_cr     = 4'b0000;
        case (r_state)
            FILL_Y: begin
                if (w_beat) begin
                    if (ch_in == CH_Y && valid_in == 4'b0001) begin
                        w_we_y     = 4'b0001 << r_ycnt;
                        w_ycnt_nxt = r_ycnt + 2'd1;
                        if (r_ycnt == 2'd3) begin
                            w_state_nxt = FILL_CB;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            FILL_CB: begin
                if (w_beat) begin
                    if (ch_in == CH_CB && valid_in == 4'b1111) begin
                        w_we_cb     = 4'b1111;
                        w_state_nxt = FILL_CR;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            FILL_CR: begin
                if (w_beat) begin
                    if (ch_in == CH_CR && valid_in == 4'b1111) begin
                        w_we_cr     = 4'b1111;
                        w_state_nxt = DRAIN;
                        w_bcnt_nxt  = 2'd0;
                        w_rcnt_nxt  = 3'd0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Not ready while draining, so any presented beat is dropped.
                w_err_nxt = w_beat;
                if (ready_in) begin
                    w_rcnt_nxt = r_rcnt + 3'd1;
                    if (r_rcnt == 3'd7) begin
                        w_bcnt_nxt = r_bcnt + 2'd1;
                    end
                    if (w_last) begin
                        w_state_nxt = FILL_Y;
                        w_ycnt_nxt  = 2'd0;
                    end
                end
            end
            default: w_state_nxt = FILL_Y;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL_Y;
            r_ycnt  <= 2'd0;
            r_bcnt  <= 2'd0;
            r_rcnt  <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ycnt  <= w_ycnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    mcu_block_bank u_bank_y (
        .clk     (clk),
        .i_we    (w_we_y),
        .i_wdata ({block_1_in, block_1_in, block_1_in, block_1_in}),
        .i_rblk  (r_bcnt),
        .i_rrow  (r_rcnt),
        .o_rdata (w_y_row)
    );

    mcu_block_bank u_bank_cb (
        .clk     (clk),
        .i_we    (w_we_cb),
        .i_wdata ({block_4_in, block_3_in, block_2_in, block_1_in}),
        .i_rblk  (r_bcnt),
        .i_rrow  (r_rcnt),
        .o_rdata (w_cb_row)
    );

    mcu_block_bank u_bank_cr (
        .clk     (clk),
        .i_we    (w_we_cr),
        .i_wdata ({block_4_in, block_3_in, block_2_in, block_1_in}),
        .i_rblk  (r_bcnt),
        .i_rrow  (r_rcnt),
        .o_rdata (w_cr_row)
    );

    assign valid_out = (r_state == DRAIN);
    assign ready_out = (r_state != DRAIN);
    assign err_out   = r_err;
    assign y_out     = valid_out ? w_y_row  : '0;
    assign cb_out    = valid_out ? w_cb_row : '0;
    assign cr_out    = valid_out ? w_cr_row : '0;
    assign blk_out   = valid_out ? r_bcnt   : 2'd0;
    assign row_out   = valid_out ? r_rcnt   : 3'd0;
    assign last_out  = valid_out && w_last;

endmodule
